// File: rtl/ucsbece154b_mem_arbiter.sv
// Memory-port arbiter: shares the main-memory port between icache line
// refills (BLOCK_WORDS-word read bursts) and single-word data accesses.
// Round-robin on ties, registered grant, mandatory IDLE turnaround cycle,
// and three saturating performance counters.
module ucsbece154b_mem_arbiter #(
    parameter int BLOCK_WORDS = 4
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic                           ic_req_i,
    input  logic [31:0]                    ic_addr_i,
    output logic                           ic_ready_o,
    output logic [31:0]                    ic_data_o,
    output logic [$clog2(BLOCK_WORDS)-1:0] ic_word_o,

    input  logic                           dm_req_i,
    input  logic                           dm_we_i,
    input  logic [31:0]                    dm_addr_i,
    input  logic [31:0]                    dm_wdata_i,
    output logic [31:0]                    dm_rdata_o,
    output logic                           dm_done_o,

    output logic                           mem_req_o,
    output logic                           mem_burst_o,
    output logic                           mem_we_o,
    output logic [31:0]                    mem_addr_o,
    output logic [31:0]                    mem_wdata_o,
    input  logic [31:0]                    mem_rdata_i,
    input  logic                           mem_valid_i,

    output logic [31:0]                    ic_grants_o,
    output logic [31:0]                    dm_grants_o,
    output logic [31:0]                    conflict_cycles_o
);

    localparam int WW = $clog2(BLOCK_WORDS);
    localparam logic [WW-1:0] LAST_WORD = WW'(BLOCK_WORDS - 1);
    // Clears the word-in-line and byte-in-word bits of a refill address.
    localparam logic [31:0] LINE_MASK = ~((32'd1 << (WW + 2)) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        IC_BURST,
        DM_ACCESS
    } state_t;

    typedef enum logic {
        GRANT_IC,
        GRANT_DM
    } grant_t;

    state_t          state;
    state_t          state_next;
    grant_t          last_grant;
    logic [WW-1:0]   word_cnt;
    logic            grant_ic;
    logic            grant_dm;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // Next-state, arbitration decision and combinational response outputs.
    always_comb begin
        state_next = state;
        grant_ic   = 1'b0;
        grant_dm   = 1'b0;
        ic_ready_o = 1'b0;
        ic_data_o  = '0;
        dm_done_o  = 1'b0;
        dm_rdata_o = '0;
        case (state)
            IDLE: begin
                if (ic_req_i && (!dm_req_i || last_grant == GRANT_DM)) begin
                    grant_ic   = 1'b1;
                    state_next = IC_BURST;
                end else if (dm_req_i) begin
                    grant_dm   = 1'b1;
                    state_next = DM_ACCESS;
                end
            end
            IC_BURST: begin
                if (mem_valid_i) begin
                    ic_ready_o = !reset;
                    ic_data_o  = reset ? '0 : mem_rdata_i;
                    if (word_cnt == LAST_WORD) begin
                        state_next = IDLE;
                    end
                end
            end
            DM_ACCESS: begin
                if (mem_valid_i) begin
                    dm_done_o  = !reset;
                    dm_rdata_o = (reset || mem_we_o) ? '0 : mem_rdata_i;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ic_word_o = word_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered memory-side request, captured at grant and held until done.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_o   <= 1'b0;
            mem_burst_o <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            last_grant  <= GRANT_DM;
        end else if (grant_ic) begin
            mem_req_o   <= 1'b1;
            mem_burst_o <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= ic_addr_i & LINE_MASK;
            mem_wdata_o <= '0;
            last_grant  <= GRANT_IC;
        end else if (grant_dm) begin
            mem_req_o   <= 1'b1;
            mem_burst_o <= 1'b0;
            mem_we_o    <= dm_we_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
            last_grant  <= GRANT_DM;
        end else if (state != IDLE && state_next == IDLE) begin
            mem_req_o   <= 1'b0;
            mem_burst_o <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end
    end

    // Refill word counter; advances only on valid words inside a burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt <= '0;
        end else if (state == IC_BURST && mem_valid_i) begin
            word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
        end
    end

    // Saturating grant and conflict performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            ic_grants_o       <= '0;
            dm_grants_o       <= '0;
            conflict_cycles_o <= '0;
        end else begin
            if (grant_ic) begin
                ic_grants_o <= sat_inc(ic_grants_o);
            end
            if (grant_dm) begin
                dm_grants_o <= sat_inc(dm_grants_o);
            end
            if (state == IDLE && ic_req_i && dm_req_i) begin
                conflict_cycles_o <= sat_inc(conflict_cycles_o);
            end
        end
    end

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Bench for the memory-port arbiter: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-level model.
module tb_ucsbece154b_mem_arbiter;

    localparam int BW = 4;
    localparam int WW = $clog2(BW);
    localparam logic [31:0] LINE_BYTES = BW * 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req;
    logic [31:0]   ic_addr;
    logic          ic_ready;
    logic [31:0]   ic_data;
    logic [WW-1:0] ic_word;
    logic          dm_req;
    logic          dm_we;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_wdata;
    logic [31:0]   dm_rdata;
    logic          dm_done;
    logic          mem_req;
    logic          mem_burst;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_valid;
    logic [31:0]   ic_grants;
    logic [31:0]   dm_grants;
    logic [31:0]   conflicts;

    always #5 clk = ~clk;

    ucsbece154b_mem_arbiter #(.BLOCK_WORDS(BW)) dut (
        .clk               (clk),
        .reset             (reset),
        .ic_req_i          (ic_req),
        .ic_addr_i         (ic_addr),
        .ic_ready_o        (ic_ready),
        .ic_data_o         (ic_data),
        .ic_word_o         (ic_word),
        .dm_req_i          (dm_req),
        .dm_we_i           (dm_we),
        .dm_addr_i         (dm_addr),
        .dm_wdata_i        (dm_wdata),
        .dm_rdata_o        (dm_rdata),
        .dm_done_o         (dm_done),
        .mem_req_o         (mem_req),
        .mem_burst_o       (mem_burst),
        .mem_we_o          (mem_we),
        .mem_addr_o        (mem_addr),
        .mem_wdata_o       (mem_wdata),
        .mem_rdata_i       (mem_rdata),
        .mem_valid_i       (mem_valid),
        .ic_grants_o       (ic_grants),
        .dm_grants_o       (dm_grants),
        .conflict_cycles_o (conflicts)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: who owns the port, how many words are done.
    int          owner;       // 0 = nobody, 1 = icache, 2 = data
    int          words_done;
    bit          last_dm;
    bit          ic_fin;
    bit          dm_fin;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    bit          m_we;
    logic [31:0] m_icg;
    logic [31:0] m_dmg;
    logic [31:0] m_conf;

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic check_outputs();
        bit valid_ic;
        bit valid_dm;
        valid_ic = (owner == 1) && mem_valid;
        valid_dm = (owner == 2) && mem_valid;
        check("mem_req",   32'(mem_req),   32'(owner != 0));
        check("mem_burst", 32'(mem_burst), 32'(owner == 1));
        check("mem_we",    32'(mem_we),    32'(owner == 2 && m_we));
        if (owner != 0) check("mem_addr", mem_addr, m_addr);
        if (owner == 2) check("mem_wdata", mem_wdata, m_wdata);
        check("ic_ready",  32'(ic_ready),  32'(valid_ic));
        if (valid_ic) check("ic_data", ic_data, mem_rdata);
        check("ic_word",   32'(ic_word),   32'(words_done));
        check("dm_done",   32'(dm_done),   32'(valid_dm));
        check("dm_rdata",  dm_rdata, (valid_dm && !m_we) ? mem_rdata : 32'd0);
        check("ic_grants", ic_grants, m_icg);
        check("dm_grants", dm_grants, m_dmg);
        check("conflicts", conflicts, m_conf);
    endtask

    task automatic model_step();
        ic_fin = 0;
        dm_fin = 0;
        if (reset) begin
            owner = 0; words_done = 0; last_dm = 1;
            m_icg = 0; m_dmg = 0; m_conf = 0;
            m_addr = 0; m_wdata = 0; m_we = 0;
            return;
        end
        if (owner == 0) begin
            if (ic_req && dm_req) m_conf = sat(m_conf);
            if (ic_req && (!dm_req || last_dm)) begin
                owner = 1; last_dm = 0; m_icg = sat(m_icg);
                m_addr = (ic_addr / LINE_BYTES) * LINE_BYTES;
            end else if (dm_req) begin
                owner = 2; last_dm = 1; m_dmg = sat(m_dmg);
                m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
            end
        end else if (owner == 1) begin
            if (mem_valid) begin
                words_done++;
                if (words_done == BW) begin
                    words_done = 0; owner = 0; ic_fin = 1;
                end
            end
        end else if (mem_valid) begin
            owner = 0; dm_fin = 1;
        end
    endtask

    // One clock: called at a falling edge with inputs already applied.
    task automatic step();
        #1;
        if (!reset) check_outputs();
        model_step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1; ic_req = 0; ic_addr = 0; dm_req = 0; dm_we = 0;
        dm_addr = 0; dm_wdata = 0; mem_rdata = 0; mem_valid = 0;
        step(); step();
        reset = 0;
        step();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_ic_grants", ic_grants, 32'd0);

        // Icache burst with gaps between valid words
        ic_req = 1; ic_addr = 32'h0001_0014;
        step();
        check("t1_addr", mem_addr, 32'h0001_0010);
        check("t1_burst", 32'(mem_burst), 32'd1);
        for (int k = 0; k < BW; k++) begin
            mem_valid = 0;
            step();
            mem_valid = 1; mem_rdata = 32'hA0 + 32'(k);
            #1;
            check("t1_word", 32'(ic_word), 32'(k));
            check("t1_data", ic_data, 32'hA0 + 32'(k));
            step();
        end
        check("t1_req_low", 32'(mem_req), 32'd0);
        check("t1_grants", ic_grants, 32'd1);
        ic_req = 0; mem_valid = 0;
        step();

        // Data write acknowledged on the third request cycle
        dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        step();
        step(); step();
        mem_valid = 1; mem_rdata = 32'h5555_AAAA;
        #1;
        check("t2_done", 32'(dm_done), 32'd1);
        check("t2_rdata", dm_rdata, 32'd0);
        step();
        dm_req = 0; mem_valid = 0;
        check("t2_grants", dm_grants, 32'd1);
        step();

        // Simultaneous requests after reset: icache first, then data
        reset = 1; step(); reset = 0;
        ic_req = 1; dm_req = 1; dm_we = 0; dm_addr = 32'h300; ic_addr = 32'h0000_2000;
        step();
        check("t3_ic_first", 32'(mem_burst), 32'd1);
        mem_valid = 1;
        repeat (BW) step();
        ic_req = 0; mem_valid = 0;
        step();
        check("t3_dm_second", 32'(mem_req & ~mem_burst), 32'd1);
        check("t3_conflicts", conflicts, 32'd1);
        mem_valid = 1;
        step();
        // Both held high: grants must alternate
        ic_req = 1; mem_valid = 1;
        repeat (3 * (BW + 2)) step();
        ic_req = 0; dm_req = 0; mem_valid = 0;
        repeat (BW + 2) begin
            mem_valid = (owner != 0);
            step();
        end
        mem_valid = 0;
        step();

        // Data request arriving in the final icache valid cycle
        ic_req = 1; ic_addr = 32'h0004_0008;
        step();
        mem_valid = 1;
        repeat (BW - 1) step();
        dm_req = 1; dm_we = 0; dm_addr = 32'h400;
        step();
        ic_req = 0; mem_valid = 0;
        check("t4_turnaround", 32'(mem_req), 32'd0);
        step();
        check("t4_dm_grant", 32'(mem_req & ~mem_burst), 32'd1);
        mem_valid = 1;
        step();
        dm_req = 0; mem_valid = 0;
        step();

        // Reset in the middle of a burst
        ic_req = 1; ic_addr = 32'h0008_0000;
        step();
        mem_valid = 1;
        step(); step();
        reset = 1; mem_valid = 0;
        step();
        reset = 0; ic_req = 0;
        check("t5_req", 32'(mem_req), 32'd0);
        check("t5_icg", ic_grants, 32'd0);
        check("t5_dmg", dm_grants, 32'd0);
        check("t5_conf", conflicts, 32'd0);
        mem_valid = 1;
        #1;
        check("t5_stray", 32'(ic_ready), 32'd0);
        step();
        mem_valid = 0;

        // Data read
        dm_req = 1; dm_we = 0; dm_addr = 32'h200;
        step();
        step();
        mem_valid = 1; mem_rdata = 32'h1234_5678;
        #1;
        check("t6_rdata", dm_rdata, 32'h1234_5678);
        step();
        dm_req = 0; mem_valid = 0;
        #1;
        check("t6_rdata_idle", dm_rdata, 32'd0);
        step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (reset) begin
                ic_req = 0; dm_req = 0; mem_valid = 0;
            end else begin
                if (!ic_req) begin
                    if ($urandom_range(0, 3) == 0) begin
                        ic_req = 1; ic_addr = $urandom;
                    end
                end else if (ic_fin && $urandom_range(0, 1) == 0) begin
                    ic_req = 0;
                end else if (owner == 1 && $urandom_range(0, 63) == 0) begin
                    ic_req = 0;
                end
                if (!dm_req) begin
                    if ($urandom_range(0, 3) == 0) begin
                        dm_req = 1; dm_we = 1'($urandom_range(0, 1));
                        dm_addr = $urandom; dm_wdata = $urandom;
                    end
                end else if (dm_fin && $urandom_range(0, 1) == 0) begin
                    dm_req = 0;
                end
                mem_valid = (owner != 0) ? ($urandom_range(0, 2) == 0)
                                         : ($urandom_range(0, 7) == 0);
                mem_rdata = $urandom;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
